io_input_ctrl: RTL and testbench

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

---
 rtl/io_pkg.sv | 39 +++
 rtl/io_input_ctrl_if.sv | 27 ++
 rtl/debounce_vec.sv | 59 +++++
 rtl/io_input_ctrl.sv | 102 ++++++++++
 tb/tb_io_input_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared constants and helpers for the push-button / slide-switch input block:
//   DBITS        - processor data/address width
//   *_ADDR       - memory-mapped register addresses
//   RDY_BIT/OVR_BIT - flag bit positions inside KCTRL/SCTRL
//   flags_t      - {OVR, RDY} status pair, packed in register bit order
//   next_flags() - ready/overrun update rule shared by keys and switches
// ----------------------------------------------------------------------------
package io_pkg;

    localparam int unsigned DBITS = 16;

    localparam logic [15:0] KDATA_ADDR = 16'hFFF0;
    localparam logic [15:0] SDATA_ADDR = 16'hFFF2;
    localparam logic [15:0] KCTRL_ADDR = 16'hFFF4;
    localparam logic [15:0] SCTRL_ADDR = 16'hFFF6;

    localparam int unsigned RDY_BIT = 0;
    localparam int unsigned OVR_BIT = 1;

    typedef struct packed {
        logic ovr;
        logic rdy;
    } flags_t;

    // An event always leaves RDY set, even when a data read tries to clear it
    // in the same cycle. OVR is raised only when an unconsumed RDY is being
    // overwritten, and that raise beats a concurrent write-1-to-clear.
    function automatic flags_t next_flags(flags_t cur, logic evt, logic rd_clr, logic w1c);
        flags_t nxt;
        logic   set_ovr;
        set_ovr = evt & cur.rdy & ~rd_clr;
        nxt.rdy = evt | (cur.rdy & ~rd_clr);
        nxt.ovr = set_ovr | (cur.ovr & ~w1c);
        return nxt;
    endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// io_input_ctrl_if
// Processor memory-stage bus as seen by the input block.
//   ADDR - data address          RE  - load strobe     WE - store strobe
//   DIN  - store data            DOUT - read data      HIT - address decodes here
// master: processor side, slave: io_input_ctrl side.
// ----------------------------------------------------------------------------
interface io_input_ctrl_if #(
    parameter int unsigned DBITS = io_pkg::DBITS
);
    logic [DBITS-1:0] ADDR;
    logic             RE;
    logic             WE;
    logic [DBITS-1:0] DIN;
    logic [DBITS-1:0] DOUT;
    logic             HIT;

    modport master (
        output ADDR, RE, WE, DIN,
        input  DOUT, HIT
    );

    modport slave (
        input  ADDR, RE, WE, DIN,
        output DOUT, HIT
    );
endinterface

// File: rtl/debounce_vec.sv
// ----------------------------------------------------------------------------
// debounce_vec
// W-bit synchronizer + tick-sampled debouncer.
//   CLK, RESET_N - clock, async active-low reset
//   TICK         - one-cycle sample strobe from the shared prescaler
//   RAW[W-1:0]   - asynchronous raw inputs
//   RST_VAL      - reset level for every sync/prev/state flop
//   STATE[W-1:0] - debounced vector
//   CHG          - high in the cycle whose edge changes STATE
// ----------------------------------------------------------------------------
module debounce_vec #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         TICK,
    input  logic [W-1:0] RAW,
    input  logic         RST_VAL,
    output logic [W-1:0] STATE,
    output logic         CHG
);

    logic [W-1:0] sync1_q, sync1_d;
    logic [W-1:0] sync2_q, sync2_d;
    logic [W-1:0] prev_q,  prev_d;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] agree;

    always_comb begin
        sync1_d = RAW;
        sync2_d = sync1_q;
        prev_d  = prev_q;
        state_d = state_q;
        agree   = ~(sync2_q ^ prev_q);
        if (TICK) begin
            prev_d  = sync2_q;
            // A bit follows the input only when two consecutive ticks agree.
            state_d = (sync2_q & agree) | (state_q & ~agree);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= {W{RST_VAL}};
            sync2_q <= {W{RST_VAL}};
            prev_q  <= {W{RST_VAL}};
            state_q <= {W{RST_VAL}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
        end
    end

    assign STATE = state_q;
    assign CHG   = (state_d != state_q);

endmodule

// File: rtl/io_input_ctrl.sv
// ----------------------------------------------------------------------------
// io_input_ctrl
// Memory-mapped debounced push-buttons and slide switches.
//   CLK, RESET_N - clock, async active-low reset
//   KEY[3:0]     - raw active-low push-buttons
//   SW[9:0]      - raw slide switches
//   bus          - processor bus (ADDR/RE/WE/DIN in, DOUT/HIT out)
// Registers: FFF0 KDATA (1 = pressed), FFF2 SDATA, FFF4 KCTRL {OVR,RDY},
// FFF6 SCTRL {OVR,RDY}. RDY clears on an RE read of the data register,
// OVR clears by writing 1 to DIN[1] of the control register.
// ----------------------------------------------------------------------------
module io_input_ctrl #(
    parameter int unsigned DBITS      = io_pkg::DBITS,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [3:0]     KEY,
    input  logic [9:0]     SW,
    io_input_ctrl_if.slave bus
);
    import io_pkg::*;

    localparam int unsigned PW = $clog2(DEB_CYCLES);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    logic [3:0]    key_state;
    logic [3:0]    key_pressed;
    logic          key_chg;
    logic [9:0]    sw_state;
    logic          sw_chg;

    logic          sel_kdata, sel_sdata, sel_kctrl, sel_sctrl;
    flags_t        kfl_q, kfl_d;
    flags_t        sfl_q, sfl_d;

    // Shared prescaler: one TICK every DEB_CYCLES clocks.
    always_comb begin
        tick  = (pre_q == PW'(DEB_CYCLES - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    debounce_vec #(.W(4)) u_key_deb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TICK    (tick),
        .RAW     (KEY),
        .RST_VAL (1'b1),
        .STATE   (key_state),
        .CHG     (key_chg)
    );

    debounce_vec #(.W(10)) u_sw_deb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TICK    (tick),
        .RAW     (SW),
        .RST_VAL (1'b0),
        .STATE   (sw_state),
        .CHG     (sw_chg)
    );

    always_comb begin
        sel_kdata = (bus.ADDR == DBITS'(KDATA_ADDR));
        sel_sdata = (bus.ADDR == DBITS'(SDATA_ADDR));
        sel_kctrl = (bus.ADDR == DBITS'(KCTRL_ADDR));
        sel_sctrl = (bus.ADDR == DBITS'(SCTRL_ADDR));

        kfl_d = next_flags(kfl_q, key_chg,
                           bus.RE & sel_kdata,
                           bus.WE & sel_kctrl & bus.DIN[OVR_BIT]);
        sfl_d = next_flags(sfl_q, sw_chg,
                           bus.RE & sel_sdata,
                           bus.WE & sel_sctrl & bus.DIN[OVR_BIT]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q <= '0;
            kfl_q <= '0;
            sfl_q <= '0;
        end else begin
            pre_q <= pre_d;
            kfl_q <= kfl_d;
            sfl_q <= sfl_d;
        end
    end

    // Read path is purely combinational from ADDR and shows pre-edge flags.
    always_comb begin
        key_pressed = ~key_state;
        bus.HIT     = sel_kdata | sel_sdata | sel_kctrl | sel_sctrl;
        bus.DOUT    = '0;
        if (sel_kdata) bus.DOUT = DBITS'(key_pressed);
        if (sel_sdata) bus.DOUT = DBITS'(sw_state);
        if (sel_kctrl) bus.DOUT = DBITS'(kfl_q);
        if (sel_sctrl) bus.DOUT = DBITS'(sfl_q);
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_io_input_ctrl
// Directed bench for io_input_ctrl with DEB_CYCLES=4. Inputs are driven and
// outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_io_input_ctrl;

    localparam logic [15:0] A_KDATA = 16'hFFF0;
    localparam logic [15:0] A_SDATA = 16'hFFF2;
    localparam logic [15:0] A_KCTRL = 16'hFFF4;
    localparam logic [15:0] A_SCTRL = 16'hFFF6;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] KEY;
    logic [9:0] SW;

    int n_checks = 0;
    int n_fail   = 0;

    io_input_ctrl_if #(.DBITS(16)) bus ();

    io_input_ctrl #(.DBITS(16), .DEB_CYCLES(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .KEY     (KEY),
        .SW      (SW),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", tag, act, exp);
        end
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d, output logic h);
        bus.ADDR = a;
        bus.RE   = 1'b0;
        bus.WE   = 1'b0;
        #1;
        d = bus.DOUT;
        h = bus.HIT;
    endtask

    task automatic expect_reg(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        h;
        peek(a, d, h);
        check_val(tag, d, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic rd_strobe(input logic [15:0] a);
        bus.ADDR = a;
        bus.RE   = 1'b1;
        @(negedge CLK);
        bus.RE   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        bus.ADDR = a;
        bus.DIN  = v;
        bus.WE   = 1'b1;
        @(negedge CLK);
        bus.WE   = 1'b0;
        bus.DIN  = '0;
    endtask

    logic [15:0] hit_addr [8] = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6,
                                  16'hFFF8, 16'hFFF1, 16'hFFEE, 16'h0000};
    logic        hit_exp  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic        h;
        logic        found;
        int          lat;

        RESET_N  = 1'b0;
        KEY      = 4'hF;
        SW       = '0;
        bus.ADDR = '0;
        bus.RE   = 1'b0;
        bus.WE   = 1'b0;
        bus.DIN  = '0;
        idle(3);

        // Reset state and address decode
        expect_reg("rst_kdata", A_KDATA, 16'h0000);
        expect_reg("rst_sdata", A_SDATA, 16'h0000);
        expect_reg("rst_kctrl", A_KCTRL, 16'h0000);
        expect_reg("rst_sctrl", A_SCTRL, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            peek(hit_addr[i], d, h);
            check_val("hit_map", {15'b0, h}, {15'b0, hit_exp[i]});
            if (!hit_exp[i]) check_val("miss_dout", d, 16'h0000);
        end
        RESET_N = 1'b1;
        idle(12);
        expect_reg("idle_kctrl", A_KCTRL, 16'h0000);
        expect_reg("idle_sctrl", A_SCTRL, 16'h0000);

        // KEY[2] press: latency, then RE read clears KRDY
        KEY   = 4'b1011;
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 14; i++) begin
            if (!found) begin
                @(negedge CLK);
                peek(A_KDATA, d, h);
                if (d == 16'h0004) begin
                    found = 1'b1;
                    lat   = i;
                end
            end
        end
        check_val("k2_latency_ok", {15'b0, found && (lat <= 11)}, 16'h0001);
        expect_reg("k2_kdata", A_KDATA, 16'h0004);
        expect_reg("k2_krdy", A_KCTRL, 16'h0001);
        rd_strobe(A_KDATA);
        expect_reg("k2_rd_clr", A_KCTRL, 16'h0000);
        idle(20 - lat - 1);
        KEY = 4'hF;
        idle(14);
        expect_reg("k2_rel_kdata", A_KDATA, 16'h0000);
        expect_reg("k2_rel_kctrl", A_KCTRL, 16'h0001);

        // Unmapped read, control read, and ignored writes leave flags alone
        peek(16'hFFF8, d, h);
        check_val("fff8_hit", {15'b0, h}, 16'h0000);
        check_val("fff8_dout", d, 16'h0000);
        rd_strobe(16'hFFF8);
        expect_reg("fff8_rd_keeps", A_KCTRL, 16'h0001);
        rd_strobe(A_KCTRL);
        expect_reg("kctrl_rd_keeps", A_KCTRL, 16'h0001);
        wr(A_KDATA, 16'hFFFF);
        expect_reg("kdata_wr_ign", A_KDATA, 16'h0000);
        wr(A_KCTRL, 16'h0001);
        expect_reg("kctrl_din0_ign", A_KCTRL, 16'h0001);
        rd_strobe(A_KDATA);
        expect_reg("k_clr_again", A_KCTRL, 16'h0000);

        // Short glitch on KEY[0] is ignored
        KEY = 4'b1110;
        idle(3);
        KEY = 4'hF;
        idle(14);
        expect_reg("glitch_kdata", A_KDATA, 16'h0000);
        expect_reg("glitch_kctrl", A_KCTRL, 16'h0000);

        // Switches: two unread events -> overrun, then W1C
        SW = 10'h3FF;
        idle(14);
        expect_reg("sw_on_sdata", A_SDATA, 16'h03FF);
        expect_reg("sw_on_sctrl", A_SCTRL, 16'h0001);
        SW = 10'h000;
        idle(14);
        expect_reg("sw_off_sdata", A_SDATA, 16'h0000);
        expect_reg("sw_ovr", A_SCTRL, 16'h0003);
        wr(A_SCTRL, 16'h0001);
        expect_reg("sctrl_din0_ign", A_SCTRL, 16'h0003);
        wr(A_SDATA, 16'h03FF);
        expect_reg("sdata_wr_ign", A_SDATA, 16'h0000);
        wr(A_SCTRL, 16'h0002);
        expect_reg("sovr_w1c", A_SCTRL, 16'h0001);
        rd_strobe(A_SDATA);
        expect_reg("srdy_rd_clr", A_SCTRL, 16'h0000);

        // Key event coinciding with a KDATA read: event wins
        bus.ADDR = A_KDATA;
        bus.RE   = 1'b1;
        KEY      = 4'b1101;
        found    = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (!found) begin
                @(negedge CLK);
                #1;
                if (bus.DOUT == 16'h0002) found = 1'b1;
            end
        end
        bus.RE = 1'b0;
        check_val("k1_seen", {15'b0, found}, 16'h0001);
        expect_reg("evt_beats_rd", A_KCTRL, 16'h0001);
        KEY = 4'hF;
        idle(14);
        expect_reg("kovr_set", A_KCTRL, 16'h0003);
        wr(A_KCTRL, 16'h0002);
        expect_reg("kovr_w1c", A_KCTRL, 16'h0001);
        rd_strobe(A_KDATA);
        expect_reg("krdy_clr3", A_KCTRL, 16'h0000);

        // Reset mid-debounce with KEY[0] held and switches high
        KEY = 4'b1110;
        SW  = 10'h3FF;
        idle(5);
        RESET_N = 1'b0;
        #1;
        expect_reg("mid_rst_kdata", A_KDATA, 16'h0000);
        expect_reg("mid_rst_kctrl", A_KCTRL, 16'h0000);
        expect_reg("mid_rst_sctrl", A_SCTRL, 16'h0000);
        @(negedge CLK);
        RESET_N = 1'b1;
        idle(1);
        expect_reg("post_rst_noevt", A_KCTRL, 16'h0000);
        idle(14);
        expect_reg("redeb_kdata", A_KDATA, 16'h0001);
        expect_reg("redeb_kctrl", A_KCTRL, 16'h0001);
        expect_reg("redeb_sdata", A_SDATA, 16'h03FF);
        expect_reg("redeb_sctrl", A_SCTRL, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
